hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter DRAIN_CYCLES, default 3, cycles of bubbles inserted before the HALTED state is entered (range 1..15).
REQ-002 clk  in  1  pipeline clock, all state updated on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 load_use_hazard  in  1  ID-stage load-use detection (ID load targets rs1/rs2 of IF instruction).
REQ-005 branch_EX  in  1  conditional branch resolving in EX; taken_EX  in  1  actual outcome; predict_EX  in  1  prediction made at fetch.
REQ-006 jalr_EX  in  1  jalr resolving in EX; target_EX  in  32  resolved target; pc_4_EX  in  32  fall-through address.
REQ-007 mem_busy  in  1  data memory not ready; whole pipeline freezes.
REQ-008 dbg_halt_req  in  1  level request to halt; dbg_step  in  1  single-cycle pulse, valid only while halted.
REQ-009 stall_PC, stall_IF  out  1 each  hold PC / IF register; flush_IF, flush_ID  out  1 each  bubble into IF / ID register.
REQ-010 redirect_valid  out  1; redirect_pc  out  32  PC override for next fetch.
REQ-011 halted  out  1; state  out  3  FSM encoding for debug display.
REQ-012 stall_cnt, flush_cnt  out  32 each  performance counters.

Function
REQ-013 FSM states SHALL be RUN, MEM_WAIT, HALTING, HALTED, STEP.
REQ-014 mispredict = (branch_EX & (taken_EX != predict_EX)) | jalr_EX, evaluated combinationally.
REQ-015 In RUN, priority SHALL be: mem_busy > mispredict > load_use_hazard > dbg_halt_req.
REQ-016 mem_busy in any state except HALTED SHALL assert stall_PC, stall_IF, no flush, no redirect; RUN goes to MEM_WAIT, returns to RUN the cycle after mem_busy drops; other states hold and resume their counter unchanged.
REQ-017 Mispredict SHALL, same cycle, assert redirect_valid, flush_IF, flush_ID; redirect_pc = jalr_EX ? target_EX : (taken_EX ? target_EX : pc_4_EX); load_use_hazard that cycle is ignored.
REQ-018 load_use_hazard without mispredict SHALL assert stall_PC, stall_IF, flush_ID for exactly that cycle (one bubble).
REQ-019 dbg_halt_req in RUN SHALL enter HALTING with drain counter = DRAIN_CYCLES-1; HALTING asserts stall_PC, flush_IF each cycle, counter decrements, HALTED entered when counter is 0.
REQ-020 Mispredict during HALTING SHALL still redirect and flush and reload counter to DRAIN_CYCLES-1.
REQ-021 HALTED SHALL assert halted, stall_PC, stall_IF; dbg_halt_req low returns to RUN next cycle; dbg_step pulse enters STEP.
REQ-022 STEP SHALL release exactly one fetch (no stall/flush) for one cycle, then enter HALTING regardless of dbg_halt_req.
REQ-023 Outputs other than state/halted/redirect_pc SHALL be combinational from state and inputs; redirect_pc = 0 when redirect_valid = 0.

Reset
REQ-024 rst SHALL force state RUN, drain counter 0, halted 0, counters 0; reset overrides any in-flight stall, halt or step.

Configuration
REQ-025 With HAZARD_PERF_CNT_EN defined, stall_cnt SHALL increment every cycle stall_PC=1 and flush_cnt every cycle flush_ID=1, wrapping 0xFFFFFFFF->0, frozen while HALTED.
REQ-026 Without HAZARD_PERF_CNT_EN, stall_cnt and flush_cnt SHALL be constant 0 and no counter flops synthesized.

Structure
REQ-027 FSM state enum and DRAIN_CYCLES default SHALL live in the shared package riscv_pkg.
REQ-028 Counters SHALL be one sub-module perf_counter (32-bit, enable, sync clear), instantiated twice.

Verification
REQ-029 load_use_hazard=1 for one cycle in RUN -> stall_PC=stall_IF=flush_ID=1 that cycle only, stall_cnt=1, flush_cnt=1.
REQ-030 branch_EX=1, predict_EX=0, taken_EX=1, target_EX=0x0000_0040 -> redirect_valid=1, redirect_pc=0x40, flush_IF=flush_ID=1 same cycle.
REQ-031 Mispredict with load_use_hazard=1 and mem_busy=1 same cycle -> stall only, no redirect; mem_busy drops -> redirect next cycle, state MEM_WAIT->RUN.
REQ-032 dbg_halt_req=1 in RUN, DRAIN_CYCLES=3 -> 3 HALTING cycles then halted=1; dbg_step pulse -> one STEP cycle with no stall, 3 HALTING cycles, halted=1.
REQ-033 jalr_EX=1, target_EX=0x100, during HALTING counter=1 -> redirect_pc=0x100, counter reloaded, halted rises 3 cycles later.
REQ-034 rst asserted in HALTING -> next cycle state=RUN, halted=0, counters=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared pipeline-control types, defaults and helpers
package riscv_pkg;

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_MEM_WAIT = 3'd1,
        ST_HALTING  = 3'd2,
        ST_HALTED   = 3'd3,
        ST_STEP     = 3'd4
    } hz_state_e;

    localparam int DRAIN_CYCLES_DEFAULT = 3;

    function automatic logic is_mispredict(input logic branch, input logic taken,
                                           input logic predict, input logic jalr);
        return (branch & (taken ^ predict)) | jalr;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline <-> hazard controller signal bundle
interface hazard_ctrl_if;

    logic        load_use_hazard;
    logic        branch_EX;
    logic        taken_EX;
    logic        predict_EX;
    logic        jalr_EX;
    logic [31:0] target_EX;
    logic [31:0] pc_4_EX;
    logic        mem_busy;
    logic        dbg_halt_req;
    logic        dbg_step;

    logic        stall_PC;
    logic        stall_IF;
    logic        flush_IF;
    logic        flush_ID;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halted;
    logic [2:0]  state;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    modport master (
        output load_use_hazard, branch_EX, taken_EX, predict_EX, jalr_EX,
               target_EX, pc_4_EX, mem_busy, dbg_halt_req, dbg_step,
        input  stall_PC, stall_IF, flush_IF, flush_ID, redirect_valid,
               redirect_pc, halted, state, stall_cnt, flush_cnt
    );

    modport slave (
        input  load_use_hazard, branch_EX, taken_EX, predict_EX, jalr_EX,
               target_EX, pc_4_EX, mem_busy, dbg_halt_req, dbg_step,
        output stall_PC, stall_IF, flush_IF, flush_ID, redirect_valid,
               redirect_pc, halted, state, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/perf_counter.sv
// rtl/perf_counter.sv - 32-bit wrapping event counter with enable and sync clear
module perf_counter (
    input  logic        clk,
    input  logic        clr,
    input  logic        en,
    output logic [31:0] count
);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush/redirect/debug-halt controller; HAZARD_PERF_CNT_EN adds perf counters
module hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave hz
);

    localparam logic [3:0] DRAIN_RELOAD = 4'(DRAIN_CYCLES - 1);

    hz_state_e  state_q, state_d;
    logic [3:0] drain_q, drain_d;
    logic       mispredict;
    logic       stall_pc, stall_if, flush_if, flush_id, redirect;
    logic       halted;

    assign mispredict = is_mispredict(hz.branch_EX, hz.taken_EX, hz.predict_EX, hz.jalr_EX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        drain_d  = drain_q;
        stall_pc = 1'b0;
        stall_if = 1'b0;
        flush_if = 1'b0;
        flush_id = 1'b0;
        redirect = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (hz.mem_busy) begin
                    stall_pc = 1'b1;
                    stall_if = 1'b1;
                    state_d  = ST_MEM_WAIT;
                end else if (mispredict) begin
                    redirect = 1'b1;
                    flush_if = 1'b1;
                    flush_id = 1'b1;
                end else if (hz.load_use_hazard) begin
                    stall_pc = 1'b1;
                    stall_if = 1'b1;
                    flush_id = 1'b1;
                end else if (hz.dbg_halt_req) begin
                    state_d = ST_HALTING;
                    drain_d = DRAIN_RELOAD;
                end
            end
            // One extra frozen cycle after memory recovers; a pending redirect is taken back in RUN.
            ST_MEM_WAIT: begin
                stall_pc = 1'b1;
                stall_if = 1'b1;
                if (!hz.mem_busy) begin
                    state_d = ST_RUN;
                end
            end
            ST_HALTING: begin
                if (hz.mem_busy) begin
                    stall_pc = 1'b1;
                    stall_if = 1'b1;
                end else if (mispredict) begin
                    redirect = 1'b1;
                    flush_if = 1'b1;
                    flush_id = 1'b1;
                    drain_d  = DRAIN_RELOAD;
                end else begin
                    stall_pc = 1'b1;
                    flush_if = 1'b1;
                    if (drain_q == 4'd0) begin
                        state_d = ST_HALTED;
                    end else begin
                        drain_d = drain_q - 4'd1;
                    end
                end
            end
            ST_HALTED: begin
                stall_pc = 1'b1;
                stall_if = 1'b1;
                if (!hz.dbg_halt_req) begin
                    state_d = ST_RUN;
                end else if (hz.dbg_step) begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                if (hz.mem_busy) begin
                    stall_pc = 1'b1;
                    stall_if = 1'b1;
                end else begin
                    state_d = ST_HALTING;
                    drain_d = DRAIN_RELOAD;
                end
            end
            default: begin
                state_d = ST_RUN;
                drain_d = '0;
            end
        endcase
    end

    assign halted            = (state_q == ST_HALTED);
    assign hz.halted         = halted;
    assign hz.state          = state_q;
    assign hz.stall_PC       = stall_pc;
    assign hz.stall_IF       = stall_if;
    assign hz.flush_IF       = flush_if;
    assign hz.flush_ID       = flush_id;
    assign hz.redirect_valid = redirect;
    assign hz.redirect_pc    = !redirect ? 32'h0 :
                               (hz.jalr_EX || hz.taken_EX) ? hz.target_EX : hz.pc_4_EX;

`ifdef HAZARD_PERF_CNT_EN
    perf_counter u_stall_cnt (
        .clk   (clk),
        .clr   (rst),
        .en    (stall_pc & ~halted),
        .count (hz.stall_cnt)
    );

    perf_counter u_flush_cnt (
        .clk   (clk),
        .clr   (rst),
        .en    (flush_id & ~halted),
        .count (hz.flush_cnt)
    );
`else
    assign hz.stall_cnt = 32'h0;
    assign hz.flush_cnt = 32'h0;
`endif

endmodule
